// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID decoupling queue.
package if_id_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned INST_W_DEF = 32;

  localparam logic [ADDR_W_DEF-1:0] NOP_PC   = '0;
  localparam logic [INST_W_DEF-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } if_id_entry_t;

  // Net queue operation on one edge, after flush/reset are ruled out.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } if_id_op_e;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// The array is never reset; which slots hold live data is tracked by the owner.
module if_id_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an enabled edge.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: buffers up to DEPTH {pc,inst} pairs, flushes on
// redirect, and presents zero bubbles when empty.
// Optional feature: define IF_ID_BYPASS_EN for a same-cycle IF->ID path
// when the queue is empty.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              jump_in,
  input  logic              stall_in,
  input  logic              instE_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + INST_W;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          empty;
  logic          full;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          eff_push;
  logic          eff_pop;
  logic          wr_en;
  logic [EW-1:0] head_entry;
  if_id_op_e     op;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef IF_ID_BYPASS_EN
  assign bypass = empty & instE_in & ~jump_in;
`else
  assign bypass = 1'b0;
`endif

  // ready_out depends only on occupancy, never on stall_in.
  assign ready_out = ~full;
  assign valid_out = ~empty | bypass;

  assign push = instE_in & ready_out;
  assign pop  = valid_out & ~stall_in;

  // An empty-queue pop can only be a bypassed entry: it is consumed directly
  // and never enters storage, so neither pointers nor count move.
  assign eff_pop  = pop & ~empty;
  assign eff_push = push & ~(empty & pop);
  assign wr_en    = eff_push & ~rst_in & ~jump_in;

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr (tail),
    .wr_data ({pc_in, inst_in}),
    .rd_addr (head),
    .rd_data (head_entry)
  );

  // Classify the edge's queue operation.
  always_comb begin
    op = OP_IDLE;
    unique case ({eff_pop, eff_push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  // Pointer and occupancy update; reset beats redirect beats push/pop.
  always_ff @(posedge clk_in) begin
    if (rst_in || jump_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          tail  <= tail + PW'(1);
          count <= count + CW'(1);
        end
        OP_POP: begin
          head  <= head + PW'(1);
          count <= count - CW'(1);
        end
        OP_BOTH: begin
          head <= head + PW'(1);
          tail <= tail + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output mux: head entry, bypassed input, or zero bubble.
  always_comb begin
    pc_out   = ADDR_W'(NOP_PC);
    inst_out = INST_W'(NOP_INST);
    if (!empty) begin
      pc_out   = head_entry[EW-1:INST_W];
      inst_out = head_entry[INST_W-1:0];
    end else if (bypass) begin
      pc_out   = pc_in;
      inst_out = inst_in;
    end
  end

endmodule
